// File: rtl/act_mode_ctrl.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module      : act_mode_ctrl
// Description : Activation-mode controller. Each raw activation request is
//               synchronised (2 flops) and debounced (DEB_CYCLES consecutive
//               stable cycles). A debounced rising edge latches a per-channel
//               pending bit. A two-state scheduler (IDLE/RUN) grants the
//               lowest-index pending channel, issues a one-cycle start pulse
//               and waits for that channel's done before the next grant.
//               A rising edge on a channel that is still pending is recorded
//               in a sticky overrun flag.
// Optional    : `define ACT_TIMEOUT_EN adds a RUN watchdog of TIMEOUT_CYCLES
//               cycles. Without it RUN waits for done indefinitely and
//               timeout is tied low.
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               act_in     [NUM_CH]  raw asynchronous activation requests
//               done_in    [NUM_CH]  per-channel completion from engines
//               start_out  [NUM_CH]  one-cycle one-hot start pulse
//               busy                 high while a channel is in RUN
//               grant_id   [CH_W]    index of current/last granted channel
//               overrun    [NUM_CH]  sticky lost-request flags
//               timeout              one-cycle watchdog abort pulse
// Revision    : 1.0  initial release
// ============================================================================
module act_mode_ctrl #(
    parameter int  NUM_CH         = 3,
    parameter int  DEB_CYCLES     = 16,
    parameter int  TIMEOUT_CYCLES = 65535,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] act_in,
    input  logic [NUM_CH-1:0] done_in,
    output logic [NUM_CH-1:0] start_out,
    output logic              busy,
    output logic [CH_W-1:0]   grant_id,
    output logic [NUM_CH-1:0] overrun,
    output logic              timeout
);

    // Debounce counter only has to reach DEB_CYCLES-1.
    localparam int C_CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] w_deb;
    logic [NUM_CH-1:0] r_deb_q;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_overrun;
    logic [NUM_CH-1:0] r_start;
    logic [NUM_CH-1:0] r_grant_oh;
    logic [CH_W-1:0]   r_grant_id;
    logic [CH_W-1:0]   w_sel;
    logic [NUM_CH-1:0] w_sel_oh;
    logic [NUM_CH-1:0] w_clear;
    logic              w_grant;
    logic              w_done;
    logic              w_expire;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the raw requests
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= act_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce: the level only follows the synchronised input
    // once it has differed for DEB_CYCLES consecutive cycles.
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
            logic [C_CNT_W-1:0] r_cnt;
            logic               r_level;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync2[g] == r_level) begin
                    r_cnt   <= '0;
                end else if (r_cnt == C_CNT_W'(DEB_CYCLES - 1)) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2[g];
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            assign w_deb[g] = r_level;
        end
    endgenerate

    // Registered copy of the debounced level gives a one-cycle rise strobe,
    // so pending is set the cycle after the debounced level goes high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_deb_q <= '0;
        end else begin
            r_deb_q <= w_deb;
        end
    end

    assign w_rise = w_deb & ~r_deb_q;

    // ------------------------------------------------------------------
    // Lowest-index pending channel (scan from the top so the lowest wins)
    // ------------------------------------------------------------------
    always_comb begin
        w_sel    = '0;
        w_sel_oh = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel       = CH_W'(i);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // Only the granted channel's completion is honoured.
    assign w_done = |(done_in & r_grant_oh);

    // ------------------------------------------------------------------
    // Optional RUN watchdog
    // ------------------------------------------------------------------
`ifdef ACT_TIMEOUT_EN
    localparam int C_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [C_WD_W-1:0] r_wdog;

    // Counts RUN cycles; zero in the start cycle of every RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    assign w_expire = (r_state == ST_RUN) && !w_done &&
                      (r_wdog == C_WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_expire         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving RUN always lands in IDLE for a full cycle, which guarantees
    // the idle gap between consecutive grants.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = ST_RUN;
                    w_grant     = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_done || w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clear = w_grant ? w_sel_oh : '0;

    // ------------------------------------------------------------------
    // Pending / overrun bookkeeping and grant registers
    // ------------------------------------------------------------------
    // A rise that coincides with its own grant re-arms pending and is not
    // a lost request; a rise while pending stays set is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overrun  <= '0;
            r_start    <= '0;
            r_grant_id <= '0;
            r_grant_oh <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_rise;
            r_overrun <= r_overrun | (w_rise & r_pending & ~w_clear);
            r_start   <= w_clear;
            if (w_grant) begin
                r_grant_id <= w_sel;
                r_grant_oh <= w_sel_oh;
            end
        end
    end

    assign start_out = r_start;
    assign busy      = (r_state == ST_RUN);
    assign grant_id  = r_grant_id;
    assign overrun   = r_overrun;
    assign timeout   = w_expire;

endmodule

`default_nettype wire

// File: doc/act_mode_ctrl.md
ACT_MODE_CTRL -- requirements
Module: act_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of activation channels (PC_RAM, RAM_PC, PROCESS at 0,1,2), range 1..16.
REQ-002 SHALL have parameter DEB_CYCLES, default 16, consecutive stable cycles to accept a level change, range 2..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, RUN watchdog limit (used only with ACT_TIMEOUT_EN).
REQ-004 SHALL have derived localparam CH_W = max(1, clog2(NUM_CH)).
REQ-005 Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- act_in  in  NUM_CH  raw, asynchronous, possibly glitching activation requests
- done_in  in  NUM_CH  per-channel completion from downstream engines
- start_out  out  NUM_CH  one-cycle, one-hot start pulse to granted engine
- busy  out  1  high while a channel is in RUN
- grant_id  out  CH_W  index of current/last granted channel
- overrun  out  NUM_CH  sticky per-channel lost-request flags
- timeout  out  1  one-cycle watchdog abort pulse

Function
REQ-006 Each act_in bit SHALL pass a 2-flop synchroniser before any use.
REQ-007 Per channel: counter increments each cycle synced level != debounced level, clears when equal; on the DEB_CYCLES-th consecutive differing cycle, debounced level takes synced level and counter clears.
REQ-008 Pulses or glitch trains that never hold one level for DEB_CYCLES consecutive synced cycles SHALL NOT change the debounced level.
REQ-009 A debounced 0->1 transition SHALL set the channel pending bit the following cycle; falling transitions SHALL be ignored.
REQ-010 Rising edge on a channel whose pending bit is already set SHALL set overrun[ch]; pending remains single.
REQ-011 FSM states IDLE, RUN only; IDLE with any pending -> RUN, grant lowest-index pending channel, pulse start_out[ch] one cycle, clear that pending bit, load grant_id.
REQ-012 RUN -> IDLE on done_in[grant_id]=1; done_in of other channels ignored; done_in ignored in IDLE.
REQ-013 After RUN->IDLE, at least one IDLE cycle SHALL occur before the next grant.
REQ-014 busy SHALL be 1 exactly in RUN, including the start_out cycle.
REQ-015 Rising edge of the running channel during RUN SHALL set its pending bit (serviced after done), not overrun.
REQ-016 Latency: act_in held high from a sampling edge 0 SHALL produce start_out at edge DEB_CYCLES+4 when IDLE and no lower channel pending.
REQ-017 Simultaneous pending channels SHALL be serviced in ascending index order, one RUN each.

Reset
REQ-018 rst SHALL asynchronously clear synchronisers, debounce counters, debounced levels, pending, overrun, watchdog; FSM to IDLE.
REQ-019 During/after reset: start_out=0, busy=0, grant_id=0, overrun=0, timeout=0.
REQ-020 Reset mid-RUN SHALL abort silently (no start, no timeout pulse); act_in still high after release SHALL be treated as a new rising edge after debounce.

Configuration
REQ-021 With ACT_TIMEOUT_EN defined: watchdog counts RUN cycles; reaching TIMEOUT_CYCLES without done SHALL pulse timeout one cycle, return to IDLE, keep grant_id.
REQ-022 Without ACT_TIMEOUT_EN: no watchdog logic, RUN waits indefinitely, timeout tied 0.

Verification
REQ-023 DEB_CYCLES=4: act_in[1] 0.1 ns toggle burst 30 ns, then low -> no start_out, overrun=0.
REQ-024 DEB_CYCLES=4: act_in[0] rises before edge 0, held -> start_out=3'b001 at edge 8 only, busy=1; done_in[0] edge 12 -> busy=0 at 13.
REQ-025 act_in[2] and act_in[0] rise same cycle -> start_out 001 first; after done_in[0], 100 after one IDLE cycle; grant_id 0 then 2.
REQ-026 During RUN of ch0, act_in[1] pulses twice (each held 10 cycles, gaps 10) -> overrun=3'b010, ch1 serviced once.
REQ-027 ACT_TIMEOUT_EN, TIMEOUT_CYCLES=20, no done -> timeout pulse after 20 RUN cycles, busy=0 next cycle; undefined -> busy stays 1 for 1000 cycles.
REQ-028 rst asserted mid-RUN with act_in[0] high -> all outputs 0 immediately; start_out[0] again DEB_CYCLES+4 edges after release.
